mem_port_arbiter: RTL and testbench

Parametrised successor to the two-client memory control unit. Arbitrates NCH requesters (IF, MEM, future cache/debug ports) onto the single byte-wide RAM bus. Each granted request is a multi-byte little-endian read or write. The block sequences the per-byte addresses, assembles read data and returns a one-cycle response, so clients no longer keep their own byte counters. Sits between the pipeline stages and the top-level mem_din/mem_dout/mem_a/mem_wr pins.

---
 rtl/mem_port_arbiter_pkg.sv | 30 +++
 rtl/mem_port_arbiter_if.sv | 37 +++
 rtl/mem_rr_arbiter.sv | 35 +++
 rtl/mem_port_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the multi-channel byte-wide memory port arbiter.
package mem_port_arbiter_pkg;

  // Width of one RAM data beat.
  localparam int MEM_BYTE_W = 8;

  typedef enum logic [1:0] {
    STATE_IDLE  = 2'd0,
    STATE_ISSUE = 2'd1,
    STATE_DRAIN = 2'd2,
    STATE_RESP  = 2'd3
  } state_t;

  // Width of a per-channel byte-count field (must hold WORD_BYTES itself).
  function automatic int byte_bus_w(input int word_bytes);
    return $clog2(word_bytes + 1);
  endfunction

  // Width of an encoded channel index; never zero so single-channel builds still elaborate.
  function automatic int chan_idx_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  // A count of zero or one larger than the word means "whole word".
  function automatic int eff_bytes(input int req, input int word_bytes);
    if (req == 0 || req > word_bytes) return word_bytes;
    return req;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response and RAM-pin bundle of the memory port arbiter.
interface mem_port_arbiter_if #(
  parameter int NCH        = 2,
  parameter int WORD_BYTES = 4,
  parameter int ADDR_W     = 32
);
  import mem_port_arbiter_pkg::*;

  localparam int BW = byte_bus_w(WORD_BYTES);
  localparam int DW = MEM_BYTE_W * WORD_BYTES;

  logic [NCH-1:0]        req_valid;
  logic [NCH-1:0]        req_we;
  logic [NCH*ADDR_W-1:0] req_addr;
  logic [NCH*BW-1:0]     req_bytes;
  logic [NCH*DW-1:0]     req_wdata;
  logic [NCH-1:0]        req_ready;
  logic [NCH-1:0]        resp_valid;
  logic [DW-1:0]         resp_rdata;
  logic [7:0]            mem_din;
  logic [7:0]            mem_dout;
  logic [ADDR_W-1:0]     mem_a;
  logic                  mem_wr;

  // Arbiter side: takes requests and RAM read data, drives grants, responses and RAM pins.
  modport slave (
    input  req_valid, req_we, req_addr, req_bytes, req_wdata, mem_din,
    output req_ready, resp_valid, resp_rdata, mem_dout, mem_a, mem_wr
  );

  // Client/RAM side.
  modport master (
    output req_valid, req_we, req_addr, req_bytes, req_wdata, mem_din,
    input  req_ready, resp_valid, resp_rdata, mem_dout, mem_a, mem_wr
  );

endinterface

// File: rtl/mem_rr_arbiter.sv
// Combinational request picker: fixed priority from channel 0, or round-robin from ptr.
module mem_rr_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NCH = 2,
  parameter int IW  = chan_idx_w(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  ptr,
  input  logic           rr_mode,
  output logic [NCH-1:0] grant,
  output logic [IW-1:0]  idx,
  output logic           any
);

  int base;

  // Scan candidates in priority order starting at base; the first live request wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    base  = rr_mode ? int'(ptr) : 0;
    for (int i = 0; i < NCH; i++) begin
      for (int c = 0; c < NCH; c++) begin
        if (!any && req[c] && c == ((base + i) % NCH)) begin
          grant[c] = 1'b1;
          idx      = IW'(c);
          any      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates NCH clients onto one byte-wide RAM, sequencing multi-byte little-endian transfers.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NCH        = 2,
  parameter int WORD_BYTES = 4,
  parameter int ADDR_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int RR_MODE    = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  mem_port_arbiter_if.slave bus
);

  localparam int BW = byte_bus_w(WORD_BYTES);
  localparam int DW = MEM_BYTE_W * WORD_BYTES;
  localparam int IW = chan_idx_w(NCH);

  state_t state_q, state_d;

  logic [IW-1:0]     ptr_q, win_q, arb_idx;
  logic [NCH-1:0]    arb_grant, win_oh;
  logic              arb_any;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [BW-1:0]     n_q, iss_q, cap_q;
  logic [DW-1:0]     wdata_q, rdata_q;
  logic [7:0]        wr_byte;

  // Read capture pipe: one slot per cycle of RAM latency, tagged with byte index.
  logic [RD_LAT-1:0] pipe_v_q;
  logic [BW-1:0]     pipe_idx_q [RD_LAT];

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [BW-1:0]     sel_bytes, sel_n;
  logic [DW-1:0]     sel_wdata;

  logic grant_fire, cap_fire, last_issue, cap_last, rd_active;

  mem_rr_arbiter #(.NCH(NCH), .IW(IW)) u_arb (
    .req     (bus.req_valid),
    .ptr     (ptr_q),
    .rr_mode (RR_MODE != 0),
    .grant   (arb_grant),
    .idx     (arb_idx),
    .any     (arb_any)
  );

  assign grant_fire = (state_q == STATE_IDLE) && rdy && arb_any;
  assign cap_fire   = rdy && pipe_v_q[RD_LAT-1];
  assign last_issue = (iss_q == n_q - BW'(1));
  assign cap_last   = ((cap_q + BW'(1)) == n_q);
  assign rd_active  = !we_q && (state_q == STATE_ISSUE || state_q == STATE_DRAIN);
  assign sel_n      = BW'(eff_bytes(int'(sel_bytes), WORD_BYTES));

  // Pick the winning channel's request fields for latching at grant.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_bytes = '0;
    sel_wdata = '0;
    for (int i = 0; i < NCH; i++) begin
      if (arb_idx == IW'(i)) begin
        sel_we    = bus.req_we[i];
        sel_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
        sel_bytes = bus.req_bytes[i*BW +: BW];
        sel_wdata = bus.req_wdata[i*DW +: DW];
      end
    end
  end

  // Current write byte and one-hot form of the latched winner.
  always_comb begin
    wr_byte = '0;
    win_oh  = '0;
    for (int k = 0; k < WORD_BYTES; k++) begin
      if (iss_q == BW'(k)) wr_byte = wdata_q[8*k +: 8];
    end
    for (int i = 0; i < NCH; i++) begin
      if (win_q == IW'(i)) win_oh[i] = 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= STATE_IDLE;
    else      state_q <= state_d;
  end

  // Next state and all bus outputs; every pulse and write strobe is gated by rdy.
  always_comb begin
    state_d         = state_q;
    bus.req_ready   = '0;
    bus.resp_valid  = '0;
    bus.resp_rdata  = '0;
    bus.mem_a       = '0;
    bus.mem_wr      = 1'b0;
    bus.mem_dout    = '0;
    case (state_q)
      STATE_IDLE: begin
        if (grant_fire) begin
          bus.req_ready = arb_grant;
          state_d       = STATE_ISSUE;
        end
      end
      STATE_ISSUE: begin
        bus.mem_a    = addr_q + ADDR_W'(iss_q);
        bus.mem_wr   = we_q && rdy;
        bus.mem_dout = we_q ? wr_byte : 8'h00;
        if (rdy && last_issue) state_d = we_q ? STATE_RESP : STATE_DRAIN;
      end
      STATE_DRAIN: begin
        if (cap_fire && cap_last) state_d = STATE_RESP;
      end
      STATE_RESP: begin
        if (rdy) begin
          bus.resp_valid = win_oh;
          bus.resp_rdata = rdata_q;
          state_d        = STATE_IDLE;
        end
      end
      default: state_d = STATE_IDLE;
    endcase
    // A pause discards in-flight reads, so uncaptured bytes must be issued again.
    if (!rdy && state_q == STATE_DRAIN) state_d = STATE_ISSUE;
  end

  // Transfer context, byte counters, read assembly and round-robin pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q   <= '0;
      win_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      n_q     <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      iss_q   <= '0;
      cap_q   <= '0;
    end else if (grant_fire) begin
      win_q   <= arb_idx;
      we_q    <= sel_we;
      addr_q  <= sel_addr;
      n_q     <= sel_n;
      wdata_q <= sel_wdata;
      rdata_q <= '0;
      iss_q   <= '0;
      cap_q   <= '0;
      if (RR_MODE != 0) ptr_q <= (arb_idx == IW'(NCH - 1)) ? '0 : arb_idx + IW'(1);
    end else if (rdy) begin
      if (state_q == STATE_ISSUE) iss_q <= iss_q + BW'(1);
      if (cap_fire) begin
        cap_q <= cap_q + BW'(1);
        for (int k = 0; k < WORD_BYTES; k++) begin
          if (pipe_idx_q[RD_LAT-1] == BW'(k)) rdata_q[8*k +: 8] <= bus.mem_din;
        end
      end
    end else if (rd_active) begin
      iss_q <= cap_q;
    end
  end

  // Read capture pipe; flushed on a pause since those bytes get re-issued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_v_q <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_idx_q[i] <= '0;
    end else if (rdy) begin
      pipe_v_q[0]   <= (state_q == STATE_ISSUE) && !we_q;
      pipe_idx_q[0] <= iss_q;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v_q[i]   <= pipe_v_q[i-1];
        pipe_idx_q[i] <= pipe_idx_q[i-1];
      end
    end else if (rd_active) begin
      pipe_v_q <= '0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: a fixed-priority 2-channel instance and a round-robin 3-channel instance.
module tb_mem_port_arbiter;

  typedef struct { int ch; int gap; } grant_t;
  typedef struct { int ch; logic [31:0] rdata; int lat; } resp_t;
  typedef struct { logic [31:0] a; logic [7:0] d; } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy_fx = 1'b1;
  logic rdy_rr = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  grant_t exp_g_fx[$], exp_g_rr[$];
  resp_t  exp_r_fx[$], exp_r_rr[$];
  wr_t    exp_w_fx[$];
  int     last_grant_fx = 0, last_resp_fx = 0, last_grant_rr = 0, last_resp_rr = 0;
  grant_t gfx, grr;
  resp_t  rfx, rrr;
  wr_t    wfx;

  logic [7:0] ram [4096];
  bit         ram_loaded = 1'b0;

  mem_port_arbiter_if #(.NCH(2), .WORD_BYTES(4), .ADDR_W(32)) fx ();
  mem_port_arbiter_if #(.NCH(3), .WORD_BYTES(4), .ADDR_W(32)) rr ();

  mem_port_arbiter #(.NCH(2), .WORD_BYTES(4), .ADDR_W(32), .RD_LAT(1), .RR_MODE(0)) dut_fx (
    .clk(clk), .rst(rst), .rdy(rdy_fx), .bus(fx)
  );
  mem_port_arbiter #(.NCH(3), .WORD_BYTES(4), .ADDR_W(32), .RD_LAT(1), .RR_MODE(1)) dut_rr (
    .clk(clk), .rst(rst), .rdy(rdy_rr), .bus(rr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM for the fixed instance (12-bit address alias), one-cycle read latency.
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
      ram[12'h100] <= 8'h11; ram[12'h101] <= 8'h22; ram[12'h102] <= 8'h33;
      ram[12'h103] <= 8'h44; ram[12'h104] <= 8'h55; ram[12'h105] <= 8'h66;
      ram[12'hFFE] <= 8'h77; ram[12'hFFF] <= 8'h01; ram[12'h000] <= 8'h02;
      ram[12'h001] <= 8'h88; ram[12'h201] <= 8'h99;
      ram_loaded <= 1'b1;
    end else if (fx.mem_wr) begin
      ram[fx.mem_a[11:0]] <= fx.mem_dout;
    end
    fx.mem_din <= ram[fx.mem_a[11:0]];
    rr.mem_din <= rr.mem_a[7:0] ^ 8'hA5;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int oh_idx(input logic [7:0] v);
    int r = -1;
    int n = 0;
    for (int i = 0; i < 8; i++) if (v[i]) begin r = i; n++; end
    return (n == 1) ? r : -1;
  endfunction

  // Monitor for the fixed-priority instance.
  always @(negedge clk) begin
    if (rst) begin
      if (fx.req_ready != 0) begin
        if (exp_g_fx.size() == 0) chk("fx_unexpected_grant", 64'(fx.req_ready), 0);
        else begin
          gfx = exp_g_fx.pop_front();
          chk("fx_grant_ch", oh_idx(8'(fx.req_ready)), gfx.ch);
          if (gfx.gap >= 0) chk("fx_grant_gap", cyc - last_resp_fx, gfx.gap);
        end
        last_grant_fx = cyc;
      end
      if (fx.resp_valid != 0) begin
        if (exp_r_fx.size() == 0) chk("fx_unexpected_resp", 64'(fx.resp_valid), 0);
        else begin
          rfx = exp_r_fx.pop_front();
          chk("fx_resp_ch", oh_idx(8'(fx.resp_valid)), rfx.ch);
          chk("fx_resp_rdata", fx.resp_rdata, rfx.rdata);
          chk("fx_resp_latency", cyc - last_grant_fx, rfx.lat);
        end
        last_resp_fx = cyc;
      end else begin
        chk("fx_rdata_idle_zero", fx.resp_rdata, 0);
      end
      if (fx.mem_wr) begin
        if (exp_w_fx.size() == 0) chk("fx_unexpected_write", fx.mem_wr, 0);
        else begin
          wfx = exp_w_fx.pop_front();
          chk("fx_write_addr", fx.mem_a, wfx.a);
          chk("fx_write_data", fx.mem_dout, wfx.d);
        end
      end
    end
  end

  // Monitor for the round-robin instance.
  always @(negedge clk) begin
    if (rst) begin
      if (rr.req_ready != 0) begin
        if (exp_g_rr.size() == 0) chk("rr_unexpected_grant", 64'(rr.req_ready), 0);
        else begin
          grr = exp_g_rr.pop_front();
          chk("rr_grant_ch", oh_idx(8'(rr.req_ready)), grr.ch);
          if (grr.gap >= 0) chk("rr_grant_gap", cyc - last_resp_rr, grr.gap);
        end
        last_grant_rr = cyc;
      end
      if (rr.resp_valid != 0) begin
        if (exp_r_rr.size() == 0) chk("rr_unexpected_resp", 64'(rr.resp_valid), 0);
        else begin
          rrr = exp_r_rr.pop_front();
          chk("rr_resp_ch", oh_idx(8'(rr.resp_valid)), rrr.ch);
          chk("rr_resp_rdata", rr.resp_rdata, rrr.rdata);
          chk("rr_resp_latency", cyc - last_grant_rr, rrr.lat);
        end
        last_resp_rr = cyc;
      end
      if (rr.mem_wr) chk("rr_unexpected_write", rr.mem_wr, 0);
    end
  end

  task automatic eg_fx(input int ch, input int gap);
    grant_t g; g.ch = ch; g.gap = gap; exp_g_fx.push_back(g);
  endtask
  task automatic er_fx(input int ch, input logic [31:0] d, input int lat);
    resp_t r; r.ch = ch; r.rdata = d; r.lat = lat; exp_r_fx.push_back(r);
  endtask
  task automatic ew_fx(input logic [31:0] a, input logic [7:0] d);
    wr_t w; w.a = a; w.d = d; exp_w_fx.push_back(w);
  endtask
  task automatic eg_rr(input int ch, input int gap);
    grant_t g; g.ch = ch; g.gap = gap; exp_g_rr.push_back(g);
  endtask
  task automatic er_rr(input int ch, input logic [31:0] d, input int lat);
    resp_t r; r.ch = ch; r.rdata = d; r.lat = lat; exp_r_rr.push_back(r);
  endtask

  task automatic fx_drive(input int ch, input logic we, input logic [31:0] addr,
                          input logic [2:0] bytes, input logic [31:0] wdata);
    fx.req_we[ch]              = we;
    fx.req_addr[ch*32 +: 32]   = addr;
    fx.req_bytes[ch*3 +: 3]    = bytes;
    fx.req_wdata[ch*32 +: 32]  = wdata;
    fx.req_valid[ch]           = 1'b1;
  endtask

  task automatic fx_wait_grant(input int ch);
    bit got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (fx.req_ready[ch]) got = 1'b1;
    end
    chk("fx_request_granted", got, 1);
  endtask

  task automatic fx_req(input int ch, input logic we, input logic [31:0] addr,
                        input logic [2:0] bytes, input logic [31:0] wdata);
    fx_drive(ch, we, addr, bytes, wdata);
    fx_wait_grant(ch);
    @(posedge clk); #1;
    fx.req_valid[ch] = 1'b0;
  endtask

  task automatic fx_wait_idle();
    for (int i = 0; i < 200 && exp_r_fx.size() != 0; i++) @(posedge clk);
    chk("fx_responses_drained", exp_r_fx.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int ng;
    fx.req_valid = '0; fx.req_we = '0; fx.req_addr = '0; fx.req_bytes = '0; fx.req_wdata = '0;
    rr.req_valid = '0; rr.req_we = '0; rr.req_addr = '0; rr.req_bytes = '0; rr.req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_fx_ctrl", {fx.req_ready, fx.resp_valid, fx.mem_wr, fx.mem_dout}, 0);
    chk("reset_fx_addr", fx.mem_a, 0);
    chk("reset_rr_ctrl", {rr.req_ready, rr.resp_valid, rr.mem_wr, rr.mem_dout, rr.mem_a}, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Single 4-byte read.
    eg_fx(0, -1); er_fx(0, 32'h4433_2211, 6);
    fx_req(0, 1'b0, 32'h100, 3'd4, 32'h0);
    fx_wait_idle();

    // Partial write across a 64K boundary.
    eg_fx(1, -1); ew_fx(32'h1FFFF, 8'hDD); ew_fx(32'h20000, 8'hCC); er_fx(1, 32'h0, 3);
    fx_req(1, 1'b1, 32'h1FFFF, 3'd2, 32'hAABB_CCDD);
    fx_wait_idle();
    chk("ram_1ffff", ram[12'hFFF], 8'hDD);
    chk("ram_20000", ram[12'h000], 8'hCC);
    chk("ram_1fffe_kept", ram[12'hFFE], 8'h77);
    chk("ram_20001_kept", ram[12'h001], 8'h88);

    // Collision in fixed mode: ch0 first, ch1 right after ch0's response; ch1 asks for 0 bytes (= 4).
    eg_fx(0, -1); eg_fx(1, 1);
    er_fx(0, 32'h0000_2211, 4); er_fx(1, 32'h6655_4433, 6);
    fork
      fx_req(0, 1'b0, 32'h100, 3'd2, 32'h0);
      fx_req(1, 1'b0, 32'h102, 3'd0, 32'h0);
    join
    fx_wait_idle();

    // Oversized count clamps to a word; single byte read zero-fills upper bytes.
    eg_fx(0, -1); er_fx(0, 32'h5544_3322, 6);
    fx_req(0, 1'b0, 32'h101, 3'd5, 32'h0);
    fx_wait_idle();
    eg_fx(1, -1); er_fx(1, 32'h0000_0044, 3);
    fx_req(1, 1'b0, 32'h103, 3'd1, 32'h0);
    fx_wait_idle();

    // Write address wraps modulo 2^32.
    eg_fx(0, -1); ew_fx(32'hFFFF_FFFF, 8'hEF); ew_fx(32'h0, 8'hBE); er_fx(0, 32'h0, 3);
    fx_req(0, 1'b1, 32'hFFFF_FFFF, 3'd2, 32'h1234_BEEF);
    fx_wait_idle();
    chk("ram_wrap_hi", ram[12'hFFF], 8'hEF);
    chk("ram_wrap_lo", ram[12'h000], 8'hBE);

    // rdy low for 3 cycles while byte 2 of a read is on the bus: 4 cycles later than normal.
    eg_fx(0, -1); er_fx(0, 32'h4433_2211, 10);
    fx_drive(0, 1'b0, 32'h100, 3'd4, 32'h0);
    fx_wait_grant(0);
    @(posedge clk); #1;
    fx.req_valid[0] = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rdy_fx = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("pause_outputs", {fx.mem_wr, fx.req_ready, fx.resp_valid}, 0);
      @(posedge clk);
    end
    #1;
    rdy_fx = 1'b1;
    fx_wait_idle();

    // Reset in cycle 2 of a write: only byte 0 lands, outputs clear at once, no response.
    eg_fx(0, -1); ew_fx(32'h200, 8'h11);
    fx_drive(0, 1'b1, 32'h200, 3'd4, 32'h4433_2211);
    fx_wait_grant(0);
    @(posedge clk); #1;
    fx.req_valid[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midreset_ctrl", {fx.req_ready, fx.resp_valid, fx.mem_wr, fx.mem_dout}, 0);
    chk("midreset_addr", fx.mem_a, 0);
    chk("midreset_rdata", fx.resp_rdata, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    chk("midreset_byte0", ram[12'h200], 8'h11);
    chk("midreset_byte1_kept", ram[12'h201], 8'h99);
    chk("midreset_writes_done", exp_w_fx.size(), 0);
    eg_fx(0, -1); er_fx(0, 32'h4433_2211, 6);
    fx_req(0, 1'b0, 32'h100, 3'd4, 32'h0);
    fx_wait_idle();

    // Round-robin with all three channels requesting continuously.
    for (int c = 0; c < 3; c++) begin
      rr.req_addr[c*32 +: 32] = 32'h100 + c;
      rr.req_bytes[c*3 +: 3]  = 3'd1;
    end
    eg_rr(0, -1); eg_rr(1, 1); eg_rr(2, 1); eg_rr(0, 1); eg_rr(1, 1); eg_rr(2, 1);
    for (int k = 0; k < 2; k++) begin
      er_rr(0, 32'hA5, 3); er_rr(1, 32'hA4, 3); er_rr(2, 32'hA7, 3);
    end
    rr.req_valid = 3'b111;
    ng = 0;
    for (int i = 0; i < 200 && ng < 6; i++) begin
      @(negedge clk);
      if (rr.req_ready != 0) ng++;
    end
    @(posedge clk); #1;
    rr.req_valid = '0;
    chk("rr_grant_count", ng, 6);
    for (int i = 0; i < 100 && exp_r_rr.size() != 0; i++) @(posedge clk);
    chk("rr_responses_drained", exp_r_rr.size(), 0);
    repeat (2) @(posedge clk);

    chk("fx_grants_left", exp_g_fx.size(), 0);
    chk("fx_writes_left", exp_w_fx.size(), 0);
    chk("rr_grants_left", exp_g_rr.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
